// File: rtl/bus_pkg.sv
// Shared types and constants for the 8088-style bus cycle arbiter.
// Optional wait-state support (TW state) is enabled with `define WAIT_STATES_EN.
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    T1,
    T2,
    T3,
    T4
`ifdef WAIT_STATES_EN
    , TW
`endif
  } bus_state_e;

  localparam int CS_MEMH = 0;
  localparam int CS_MEML = 1;
  localparam int CS_IO0  = 2;
  localparam int CS_IO1  = 3;

  localparam logic [15:0] IO0_BASE_DEF = 16'hFF00;
  localparam int          IO0_SIZE_DEF = 16;
  localparam logic [15:0] IO1_BASE_DEF = 16'h1C00;
  localparam int          IO1_SIZE_DEF = 512;

  typedef struct packed {
    logic        write;
    logic        io;
    logic [19:0] addr;
    logic [7:0]  wdata;
  } bus_req_t;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational slave decode: space + address -> active-low chip selects.
module bus_addr_decode
  import bus_pkg::*;
#(
  parameter logic [15:0] IO0_BASE = IO0_BASE_DEF,
  parameter int          IO0_SIZE = IO0_SIZE_DEF,
  parameter logic [15:0] IO1_BASE = IO1_BASE_DEF,
  parameter int          IO1_SIZE = IO1_SIZE_DEF
) (
  input  logic        io,
  input  logic [19:0] addr,
  output logic [3:0]  cs_n,
  output logic        unmapped
);

  // Compare in int so BASE+SIZE never wraps at the 16-bit boundary.
  int port;
  assign port = int'(addr[15:0]);

  logic unused_bits;
  assign unused_bits = &{1'b0, addr[18:16]};

  always_comb begin
    cs_n     = 4'hF;
    unmapped = 1'b0;
    if (!io) begin
      if (addr[19]) cs_n[CS_MEMH] = 1'b0;
      else          cs_n[CS_MEML] = 1'b0;
    end else if (port >= int'(IO0_BASE) && port < int'(IO0_BASE) + IO0_SIZE) begin
      cs_n[CS_IO0] = 1'b0;
    end else if (port >= int'(IO1_BASE) && port < int'(IO1_BASE) + IO1_SIZE) begin
      cs_n[CS_IO1] = 1'b0;
    end else begin
      unmapped = 1'b1;
    end
  end

endmodule

// File: rtl/bus_cycle_arbiter.sv
// Two-requester round-robin bus master generating T1-T2-T3-(TW)-T4 cycles.
// `define WAIT_STATES_EN adds ready-driven TW insertion after T3.
module bus_cycle_arbiter
  import bus_pkg::*;
#(
  parameter logic [15:0] IO0_BASE = IO0_BASE_DEF,
  parameter int          IO0_SIZE = IO0_SIZE_DEF,
  parameter logic [15:0] IO1_BASE = IO1_BASE_DEF,
  parameter int          IO1_SIZE = IO1_SIZE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  req_write,
  input  logic [1:0]  req_io,
  input  logic [19:0] req_addr0,
  input  logic [19:0] req_addr1,
  input  logic [7:0]  req_wdata0,
  input  logic [7:0]  req_wdata1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic        err,
  output logic [7:0]  rdata,
  output logic [19:0] Address,
  output logic        ALE,
  output logic        RD,
  output logic        WR,
  output logic [3:0]  CS,
  input  logic        ready,
  inout  wire  [7:0]  Data
);

  bus_state_e state, state_nxt;
  bus_req_t   cur_q;
  logic       cur_id, last;
  logic [1:0] cur_oh, elig;
  logic       pick, grant, in_tw, strobe, xfer_end, unmapped;
  logic [3:0] cs_dec;

  assign cur_oh = cur_id ? 2'b10 : 2'b01;
  // The requester finishing in T4 cannot be re-granted at that same edge.
  assign elig   = req & ~((state == T4) ? cur_oh : 2'b00);
  assign pick   = (elig == 2'b11) ? ~last : elig[1];
  assign grant  = (state == IDLE || state == T4) && (elig != 2'b00);

`ifdef WAIT_STATES_EN
  assign in_tw    = (state == TW);
  assign xfer_end = (state == T3 || state == TW) && ready;
`else
  logic unused_ready;
  assign unused_ready = ready;
  assign in_tw        = 1'b0;
  assign xfer_end     = (state == T3);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, T4: state_nxt = grant ? T1 : IDLE;
      T1:       state_nxt = T2;
      T2:       state_nxt = T3;
`ifdef WAIT_STATES_EN
      T3, TW:   state_nxt = ready ? T4 : TW;
`else
      T3:       state_nxt = T4;
`endif
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last    <= 1'b1;
      cur_id  <= 1'b0;
      cur_q   <= '0;
      rdata   <= 8'h00;
      Address <= 20'h00000;
    end else begin
      state <= state_nxt;
      if (grant) begin
        cur_id  <= pick;
        last    <= pick;
        cur_q   <= '{write: req_write[pick], io: req_io[pick],
                     addr:  pick ? req_addr1 : req_addr0,
                     wdata: pick ? req_wdata1 : req_wdata0};
        Address <= req_io[pick] ? {4'h0, (pick ? req_addr1[15:0] : req_addr0[15:0])}
                                : (pick ? req_addr1 : req_addr0);
      end
      if (xfer_end && !cur_q.write)
        rdata <= unmapped ? 8'hFF : Data;
    end
  end

  bus_addr_decode #(
    .IO0_BASE(IO0_BASE), .IO0_SIZE(IO0_SIZE),
    .IO1_BASE(IO1_BASE), .IO1_SIZE(IO1_SIZE)
  ) u_decode (
    .io      (cur_q.io),
    .addr    (cur_q.addr),
    .cs_n    (cs_dec),
    .unmapped(unmapped)
  );

  assign strobe = (state == T2) || (state == T3) || in_tw;
  assign gnt    = (state != IDLE) ? cur_oh : 2'b00;
  assign done   = (state == T4) ? cur_oh : 2'b00;
  assign err    = (state == T4) && unmapped;
  assign ALE    = (state == T1);
  assign RD     = ~(strobe && !cur_q.write);
  assign WR     = ~(strobe && cur_q.write);
  assign CS     = ((state == T1) || strobe) ? cs_dec : 4'hF;
  assign Data   = (strobe && cur_q.write) ? cur_q.wdata : 8'hzz;

endmodule

// File: tb/tb_bus_cycle_arbiter.sv
// Randomized bench for bus_cycle_arbiter against a phase-counter transaction model.
module tb_bus_cycle_arbiter;

  localparam int IO0B = 'hFF00, IO0S = 16, IO1B = 'h1C00, IO1S = 512;

  logic        clk = 1'b0, rst = 1'b1, ready = 1'b1;
  logic [1:0]  req = '0, req_write = '0, req_io = '0;
  logic [19:0] req_addr0 = '0, req_addr1 = '0;
  logic [7:0]  req_wdata0 = '0, req_wdata1 = '0;
  logic [1:0]  gnt, done;
  logic        err, ALE, RD, WR;
  logic [7:0]  rdata;
  logic [19:0] Address;
  logic [3:0]  CS;
  wire  [7:0]  Data;
  logic        drv_en = 1'b0;
  logic [7:0]  drv_val = '0;
  assign Data = drv_en ? drv_val : 8'hzz;

  bus_cycle_arbiter #(
    .IO0_BASE(16'(IO0B)), .IO0_SIZE(IO0S), .IO1_BASE(16'(IO1B)), .IO1_SIZE(IO1S)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_write(req_write), .req_io(req_io),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata), .Address(Address),
    .ALE(ALE), .RD(RD), .WR(WR), .CS(CS), .ready(ready), .Data(Data)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Slave memory (written through the pins) and model memory (written by the model).
  logic [7:0] sm[int];
  logic [7:0] mm[int];
  logic [15:0] io_tab[8];

  function automatic int key(input logic io, input logic [19:0] a);
    return io ? (32'h100000 | int'(a[15:0])) : int'(a);
  endfunction
  function automatic logic [7:0] dflt(input int k);
    return k[7:0] ^ k[15:8] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] rd_sm(input int k);
    return sm.exists(k) ? sm[k] : dflt(k);
  endfunction
  function automatic logic [7:0] rd_mm(input int k);
    return mm.exists(k) ? mm[k] : dflt(k);
  endfunction
  function automatic logic [3:0] exp_cs(input logic io, input logic [19:0] a);
    int x;
    x = int'(a[15:0]);
    if (!io) return a[19] ? 4'b1110 : 4'b1101;
    if (x >= IO0B && x < IO0B + IO0S) return 4'b1011;
    if (x >= IO1B && x < IO1B + IO1S) return 4'b0111;
    return 4'b1111;
  endfunction
  function automatic logic [1:0] oh(input logic b);
    return b ? 2'b10 : 2'b01;
  endfunction

  // Model: ph = 0 idle, 1..4 = T1..T4; waits repeat phase 3.
  int          ph = 0;
  logic        mcur = 1'b0, mlast = 1'b1, m_wr = 1'b0, m_io = 1'b0;
  logic [19:0] m_addr = '0, m_A = '0;
  logic [7:0]  m_wd = '0, m_rdata = '0;

  task automatic model_next();
    logic [1:0] elig;
    logic p, rdy;
`ifdef WAIT_STATES_EN
    rdy = ready;
`else
    rdy = 1'b1;
`endif
    if (rst) begin
      ph = 0; mlast = 1'b1; m_rdata = 8'h00; m_A = '0;
    end else if (ph == 0 || ph == 4) begin
      elig = req & ~((ph == 4) ? oh(mcur) : 2'b00);
      if (elig != 2'b00) begin
        p = (elig == 2'b11) ? !mlast : elig[1];
        mcur = p; mlast = p;
        m_wr = req_write[p]; m_io = req_io[p];
        m_addr = p ? req_addr1 : req_addr0;
        m_wd = p ? req_wdata1 : req_wdata0;
        m_A = m_io ? {4'h0, m_addr[15:0]} : m_addr;
        ph = 1;
      end else ph = 0;
    end else if (ph == 3) begin
      if (rdy) begin
        if (exp_cs(m_io, m_addr) == 4'hF) begin
          if (!m_wr) m_rdata = 8'hFF;
        end else if (m_wr) mm[key(m_io, m_addr)] = m_wd;
        else m_rdata = rd_mm(key(m_io, m_addr));
        ph = 4;
      end
    end else ph = ph + 1;
  endtask

  logic wpend = 1'b0;
  int   wkey = 0;
  logic [7:0] wval = '0;

  task automatic tick();
    logic io_sel, strb;
    model_next();
    @(posedge clk);
    @(negedge clk);
    io_sel = !CS[2] || !CS[3];
    if (!WR && CS != 4'hF) begin
      wpend = 1'b1; wkey = key(io_sel, Address); wval = Data;
    end else if (done != 2'b00 && wpend) begin
      sm[wkey] = wval; wpend = 1'b0;
    end else if (WR) wpend = 1'b0;
    drv_en  = !RD && CS != 4'hF;
    drv_val = rd_sm(key(io_sel, Address));
    strb = (ph == 2 || ph == 3);
    chk("gnt",   32'(gnt),   32'((ph != 0) ? oh(mcur) : 2'b00));
    chk("done",  32'(done),  32'((ph == 4) ? oh(mcur) : 2'b00));
    chk("err",   32'(err),   32'(ph == 4 && exp_cs(m_io, m_addr) == 4'hF));
    chk("ALE",   32'(ALE),   32'(ph == 1));
    chk("RD",    32'(RD),    32'(!(strb && !m_wr)));
    chk("WR",    32'(WR),    32'(!(strb && m_wr)));
    chk("CS",    32'(CS),    32'((ph >= 1 && ph <= 3) ? exp_cs(m_io, m_addr) : 4'hF));
    chk("Addr",  32'(Address), 32'(m_A));
    chk("rdata", 32'(rdata), 32'(m_rdata));
    if (strb && m_wr) chk("Data", 32'(Data), 32'(m_wd));
  endtask

  task automatic set_pl(input int i, input logic w, input logic io,
                        input logic [19:0] a, input logic [7:0] d);
    req_write[i] = w; req_io[i] = io;
    if (i == 0) begin req_addr0 = a; req_wdata0 = d; end
    else        begin req_addr1 = a; req_wdata1 = d; end
  endtask

  task automatic rand_pl(input int i);
    logic io;
    logic [19:0] a;
    io = 1'($urandom_range(0, 1));
    if (io) a = {4'($urandom), io_tab[3'($urandom_range(0, 7))]};
    else    a = {1'($urandom_range(0, 1)), 15'h0, 4'($urandom)};
    set_pl(i, 1'($urandom_range(0, 1)), io, a, 8'($urandom));
  endtask

  task automatic xfer(input int i, input logic w, input logic io,
                      input logic [19:0] a, input logic [7:0] d);
    int n;
    set_pl(i, w, io, a, d);
    req[i] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!(ph == 4 && mcur == i) && n < 30);
    if (n >= 30) chk("xfer_timeout", 32'(n), 32'(0));
    req[i] = 1'b0;
  endtask

  task automatic contend();
    int n;
    logic first;
    set_pl(0, 1'b0, 1'b0, 20'h80010, 8'h00);
    set_pl(1, 1'b0, 1'b0, 20'h00020, 8'h00);
    req = 2'b11; first = 1'b1; n = 0;
    while (req != 2'b00 && n < 40) begin
      tick(); n++;
      if (ph == 1 && first) begin chk("tp_first_gnt", 32'(gnt), 32'(2'b01)); first = 1'b0; end
      if (ph == 4) req[mcur] = 1'b0;
    end
    if (n >= 40) chk("contend_timeout", 32'(n), 32'(0));
  endtask

  initial begin
    int k, n;
    logic [7:0] old;
    io_tab[0] = 16'hFF00; io_tab[1] = 16'hFF0F; io_tab[2] = 16'hFF10; io_tab[3] = 16'h1C00;
    io_tab[4] = 16'h1DFF; io_tab[5] = 16'h1E00; io_tab[6] = 16'h0100; io_tab[7] = 16'h1BFF;
    sm[key(1'b0, 20'h80010)] = 8'hA5;
    mm[key(1'b0, 20'h80010)] = 8'hA5;

    tick(); tick();
    rst = 1'b0;

    xfer(0, 1'b0, 1'b0, 20'h80010, 8'h00);
    chk("tp_rd_a5", 32'(rdata), 32'(8'hA5));
    xfer(1, 1'b1, 1'b0, 20'h00020, 8'h3C);
    xfer(1, 1'b0, 1'b0, 20'h00020, 8'h00);
    chk("tp_rd_3c", 32'(rdata), 32'(8'h3C));

    rst = 1'b1; tick(); rst = 1'b0;
    contend();
    contend();

    xfer(0, 1'b0, 1'b1, 20'h01C05, 8'h00);
    chk("tp_io1_err", 32'(err), 32'(0));
    xfer(0, 1'b0, 1'b1, 20'h00100, 8'h00);
    chk("tp_unm_err", 32'(err), 32'(1));
    chk("tp_unm_rd", 32'(rdata), 32'(8'hFF));
    for (int i = 0; i < 8; i++) xfer(i % 2, 1'(i / 4), 1'b1, {4'hF, io_tab[i]}, 8'(i));

    // Reset in T2 of a write: nothing must commit.
    k = key(1'b0, 20'h00040);
    old = rd_sm(k);
    set_pl(0, 1'b1, 1'b0, 20'h00040, 8'h77);
    req[0] = 1'b1; n = 0;
    do begin tick(); n++; end while (ph != 2 && n < 10);
    rst = 1'b1; req = 2'b00;
    tick();
    chk("tp_abort_cs", 32'(CS), 32'(4'hF));
    chk("tp_abort_wr", 32'(WR), 32'(1));
    chk("tp_abort_gnt", 32'(gnt), 32'(0));
    rst = 1'b0;
    tick(); tick();
    chk("tp_abort_mem", 32'(rd_sm(k)), 32'(old));

`ifdef WAIT_STATES_EN
    set_pl(0, 1'b0, 1'b0, 20'h80010, 8'h00);
    req[0] = 1'b1; n = 0;
    do begin tick(); n++; end while (ph != 3 && n < 10);
    ready = 1'b0; tick(); tick(); n += 2;
    ready = 1'b1; tick(); n++;
    req[0] = 1'b0;
    chk("tw_lat", 32'(n), 32'(6));
    chk("tw_done", 32'(done), 32'(2'b01));
    chk("tw_rdata", 32'(rdata), 32'(8'hA5));
`endif

    for (int c = 0; c < 3000; c++) begin
`ifdef WAIT_STATES_EN
      ready = ($urandom_range(0, 3) != 0);
`endif
      tick();
      for (int i = 0; i < 2; i++) begin
        if (ph == 4 && mcur == 1'(i)) req[i] = 1'b0;
        else if (req[i] && ph != 0 && mcur == 1'(i)) rand_pl(i);
        else if (req[i] && $urandom_range(0, 15) == 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 2) == 0) begin rand_pl(i); req[i] = 1'b1; end
      end
    end
    req = 2'b00;
    for (int c = 0; c < 8; c++) tick();
    foreach (mm[kk]) chk("mem", 32'(rd_sm(kk)), 32'(mm[kk]));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
